// File: rtl/max_unpool_bwd.sv
// max_unpool_bwd: routes each pooled gradient back to the argmax position of
// its STRIDE x STRIDE forward window, one window (all channels) per clock.
// Optional build macro MAX_UNPOOL_ACCUM_EN: accumulate (saturating) into the
// argmax position instead of clearing/overwriting the whole output.
module max_unpool_bwd #(
  parameter int INPUT_WIDTH    = 64,
  parameter int INPUT_HEIGHT   = 64,
  parameter int INPUT_CHANNELS = 30,
  parameter int STRIDE         = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic signed [15:0] feature_map [0:INPUT_WIDTH-1][0:INPUT_HEIGHT-1][0:INPUT_CHANNELS-1],
  input  logic signed [15:0] grad_in [0:(INPUT_WIDTH/STRIDE)-1][0:(INPUT_HEIGHT/STRIDE)-1][0:INPUT_CHANNELS-1],
  output logic signed [15:0] grad_out [0:INPUT_WIDTH-1][0:INPUT_HEIGHT-1][0:INPUT_CHANNELS-1],
  output logic               busy,
  output logic               unpool_done
);

  localparam int OUT_W = INPUT_WIDTH / STRIDE;
  localparam int OUT_H = INPUT_HEIGHT / STRIDE;
  localparam int IW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int JW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int SW    = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int XW    = (INPUT_WIDTH > 1) ? $clog2(INPUT_WIDTH) : 1;
  localparam int YW    = (INPUT_HEIGHT > 1) ? $clog2(INPUT_HEIGHT) : 1;
  localparam int KW    = (INPUT_CHANNELS > 1) ? $clog2(INPUT_CHANNELS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [IW-1:0]         r_i;
  logic [JW-1:0]         r_j;
  logic                  w_start;
  logic                  w_last_j;
  logic                  w_last;
  logic [SW-1:0]         w_bx   [0:INPUT_CHANNELS-1];
  logic [SW-1:0]         w_by   [0:INPUT_CHANNELS-1];
  logic signed [15:0]    w_best [0:INPUT_CHANNELS-1];

  // Index helpers: size loop/arithmetic results to the exact array index width.
  function automatic logic [XW-1:0] xi(input int v);
    return XW'(v);
  endfunction

  function automatic logic [YW-1:0] yi(input int v);
    return YW'(v);
  endfunction

  function automatic logic [KW-1:0] ki(input int v);
    return KW'(v);
  endfunction

`ifdef MAX_UNPOOL_ACCUM_EN
  // Clamp a 17-bit sum into the signed 16-bit range.
  function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
    if (v > 17'sd32767)
      return 16'sh7fff;
    else if (v < -17'sd32768)
      return 16'sh8000;
    else
      return v[15:0];
  endfunction
`endif

  assign w_last_j = (r_j == JW'(OUT_H - 1));
  assign w_last   = w_last_j && (r_i == IW'(OUT_W - 1));
  assign busy     = (r_state == RUN) || (r_state == DONE);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  // Next-state logic; enable only matters in IDLE.
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_start = 1'b1;
          w_next  = RUN;
        end
      end
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Per-channel argmax of the current window; strict > keeps the first
  // maximum in x-outer / y-inner scan order, matching forward pooling.
  always_comb begin
    for (int k = 0; k < INPUT_CHANNELS; k++) begin
      w_bx[k]   = '0;
      w_by[k]   = '0;
      w_best[k] = feature_map[xi(int'(r_i) * STRIDE)][yi(int'(r_j) * STRIDE)][ki(k)];
      for (int x = 0; x < STRIDE; x++) begin
        for (int y = 0; y < STRIDE; y++) begin
          if (feature_map[xi(int'(r_i) * STRIDE + x)][yi(int'(r_j) * STRIDE + y)][ki(k)] > w_best[k]) begin
            w_best[k] = feature_map[xi(int'(r_i) * STRIDE + x)][yi(int'(r_j) * STRIDE + y)][ki(k)];
            w_bx[k]   = SW'(x);
            w_by[k]   = SW'(y);
          end
        end
      end
    end
  end

  // Window counters, completion flag and the gradient output array.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_i         <= '0;
      r_j         <= '0;
      unpool_done <= 1'b0;
      for (int x = 0; x < INPUT_WIDTH; x++)
        for (int y = 0; y < INPUT_HEIGHT; y++)
          for (int k = 0; k < INPUT_CHANNELS; k++)
            grad_out[xi(x)][yi(y)][ki(k)] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_i         <= '0;
            r_j         <= '0;
            unpool_done <= 1'b0;
`ifndef MAX_UNPOOL_ACCUM_EN
            // Also zeroes the rows/columns no window ever covers.
            for (int x = 0; x < INPUT_WIDTH; x++)
              for (int y = 0; y < INPUT_HEIGHT; y++)
                for (int k = 0; k < INPUT_CHANNELS; k++)
                  grad_out[xi(x)][yi(y)][ki(k)] <= '0;
`endif
          end
        end
        RUN: begin
          for (int k = 0; k < INPUT_CHANNELS; k++) begin
            for (int x = 0; x < STRIDE; x++) begin
              for (int y = 0; y < STRIDE; y++) begin
`ifdef MAX_UNPOOL_ACCUM_EN
                if ((SW'(x) == w_bx[k]) && (SW'(y) == w_by[k]))
                  grad_out[xi(int'(r_i) * STRIDE + x)][yi(int'(r_j) * STRIDE + y)][ki(k)] <=
                    sat16({grad_out[xi(int'(r_i) * STRIDE + x)][yi(int'(r_j) * STRIDE + y)][ki(k)][15],
                           grad_out[xi(int'(r_i) * STRIDE + x)][yi(int'(r_j) * STRIDE + y)][ki(k)]} +
                          {grad_in[r_i][r_j][ki(k)][15], grad_in[r_i][r_j][ki(k)]});
`else
                grad_out[xi(int'(r_i) * STRIDE + x)][yi(int'(r_j) * STRIDE + y)][ki(k)] <=
                  ((SW'(x) == w_bx[k]) && (SW'(y) == w_by[k])) ? grad_in[r_i][r_j][ki(k)] : '0;
`endif
              end
            end
          end
          // j runs fastest; i advances when j wraps.
          if (w_last_j) begin
            r_j <= '0;
            r_i <= w_last ? '0 : r_i + 1'b1;
          end else begin
            r_j <= r_j + 1'b1;
          end
        end
        DONE:    unpool_done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_max_unpool_bwd.sv
// Self-checking bench for max_unpool_bwd: 5x4x2 map, stride 2 (row 4 never
// belongs to a window), directed test-plan cases plus randomized passes.
module tb_max_unpool_bwd;

  localparam int W    = 5;
  localparam int H    = 4;
  localparam int C    = 2;
  localparam int S    = 2;
  localparam int OW   = W / S;
  localparam int OH   = H / S;
  localparam int NWIN = OW * OH;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic signed [15:0] fm [0:W-1][0:H-1][0:C-1];
  logic signed [15:0] gi [0:OW-1][0:OH-1][0:C-1];
  logic signed [15:0] go [0:W-1][0:H-1][0:C-1];
  logic busy;
  logic unpool_done;

  int exp_go [0:W-1][0:H-1][0:C-1];
  int n_chk  = 0;
  int n_pass = 0;

  max_unpool_bwd #(
    .INPUT_WIDTH(W), .INPUT_HEIGHT(H), .INPUT_CHANNELS(C), .STRIDE(S)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .feature_map(fm), .grad_in(gi), .grad_out(go),
    .busy(busy), .unpool_done(unpool_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Number of output elements that differ from the reference array.
  function automatic int go_diff();
    int cnt = 0;
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++)
        for (int k = 0; k < C; k++)
          if (int'(go[x][y][k]) != exp_go[x][y][k]) cnt++;
    return cnt;
  endfunction

  function automatic int go_nonzero();
    int cnt = 0;
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++)
        for (int k = 0; k < C; k++)
          if (go[x][y][k] != 0) cnt++;
    return cnt;
  endfunction

  task automatic model_zero();
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++)
        for (int k = 0; k < C; k++)
          exp_go[x][y][k] = 0;
  endtask

  // Reference for one window n (i = n / OH, j = n % OH): find the first
  // maximum in scan order, then route the gradient there.
  task automatic model_window(input int n);
    int i, j, best, bx, by, v, s;
    i = n / OH;
    j = n % OH;
    for (int k = 0; k < C; k++) begin
      best = fm[i*S][j*S][k];
      bx = 0;
      by = 0;
      for (int x = 0; x < S; x++)
        for (int y = 0; y < S; y++) begin
          v = fm[i*S+x][j*S+y][k];
          if (v > best) begin best = v; bx = x; by = y; end
        end
      for (int x = 0; x < S; x++)
        for (int y = 0; y < S; y++) begin
`ifdef MAX_UNPOOL_ACCUM_EN
          if (x == bx && y == by) begin
            s = exp_go[i*S+x][j*S+y][k] + int'(gi[i][j][k]);
            if (s > 32767) s = 32767;
            if (s < -32768) s = -32768;
            exp_go[i*S+x][j*S+y][k] = s;
          end
`else
          s = (x == bx && y == by) ? int'(gi[i][j][k]) : 0;
          exp_go[i*S+x][j*S+y][k] = s;
`endif
        end
    end
  endtask

  task automatic randomize_inputs();
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++)
        for (int k = 0; k < C; k++)
          fm[x][y][k] = 16'(int'($urandom_range(0, 6)) - 3);
    for (int i = 0; i < OW; i++)
      for (int j = 0; j < OH; j++)
        for (int k = 0; k < C; k++)
          gi[i][j][k] = 16'($urandom);
  endtask

  // One full pass; hold = enable level kept at the end, jitter = random
  // enable toggling while the pass is running.
  task automatic run_pass(input bit hold, input bit jitter);
    enable = 1'b1;
    tick();
`ifndef MAX_UNPOOL_ACCUM_EN
    model_zero();
`endif
    check("start_busy", int'(busy), 1);
    check("start_done", int'(unpool_done), 0);
    check("start_grad", go_diff(), 0);
    for (int n = 0; n < NWIN; n++) begin
      enable = jitter ? 1'($urandom_range(0, 1)) : hold;
      tick();
      model_window(n);
      check($sformatf("win%0d_grad", n), go_diff(), 0);
      check($sformatf("win%0d_busy", n), int'(busy), 1);
      check($sformatf("win%0d_done", n), int'(unpool_done), 0);
    end
    enable = hold;
    tick();
    check("end_done", int'(unpool_done), 1);
    check("end_busy", int'(busy), 0);
    check("end_grad", go_diff(), 0);
  endtask

  initial begin
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++)
        for (int k = 0; k < C; k++)
          fm[x][y][k] = '0;
    for (int i = 0; i < OW; i++)
      for (int j = 0; j < OH; j++)
        for (int k = 0; k < C; k++)
          gi[i][j][k] = '0;
    model_zero();

    // Reset state
    reset_n = 1'b0;
    repeat (2) tick();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(unpool_done), 0);
    check("rst_grad", go_nonzero(), 0);
    reset_n = 1'b1;
    tick();

    // Basic argmax: window (0,0) ch0 = {1,5,3,2}, gradient 7
    randomize_inputs();
    fm[0][0][0] = 16'sd1;
    fm[0][1][0] = 16'sd5;
    fm[1][0][0] = 16'sd3;
    fm[1][1][0] = 16'sd2;
    gi[0][0][0] = 16'sd7;
    run_pass(1'b0, 1'b0);
`ifndef MAX_UNPOOL_ACCUM_EN
    check("tp_argmax", int'(go[0][1][0]), 7);
    check("tp_other00", int'(go[0][0][0]), 0);
    check("tp_other11", int'(go[1][1][0]), 0);
    check("tp_row4", int'(go[4][2][1]), 0);
`endif

    // Ties: all-equal window and negative data with tied maxima
    randomize_inputs();
    fm[0][0][0] = 16'sd4;  fm[0][1][0] = 16'sd4;
    fm[1][0][0] = 16'sd4;  fm[1][1][0] = 16'sd4;
    gi[0][0][0] = -16'sd3;
    fm[0][0][1] = -16'sd8; fm[0][1][1] = -16'sd2;
    fm[1][0][1] = -16'sd9; fm[1][1][1] = -16'sd2;
    gi[0][0][1] = 16'sd10;
    run_pass(1'b0, 1'b0);
`ifndef MAX_UNPOOL_ACCUM_EN
    check("tie_first", int'(go[0][0][0]), -3);
    check("tie_other", int'(go[1][1][0]), 0);
    check("neg_first", int'(go[0][1][1]), 10);
    check("neg_tied2", int'(go[1][1][1]), 0);
`endif

    // IDLE with enable low holds everything
    enable = 1'b0;
    repeat (3) tick();
    check("idle_done", int'(unpool_done), 1);
    check("idle_busy", int'(busy), 0);
    check("idle_grad", go_diff(), 0);

    // Reset mid-run after two windows
    randomize_inputs();
    enable = 1'b1;
    tick();
    enable = 1'b0;
    repeat (2) tick();
    reset_n = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(unpool_done), 0);
    check("midrst_grad", go_nonzero(), 0);
    tick();
    reset_n = 1'b1;
    model_zero();
    randomize_inputs();
    run_pass(1'b0, 1'b0);

    // enable held high: back-to-back passes start right after unpool_done
    randomize_inputs();
    run_pass(1'b1, 1'b0);
    randomize_inputs();
    run_pass(1'b1, 1'b0);

    // Randomized passes with enable jitter during RUN
    repeat (4) begin
      randomize_inputs();
      run_pass(1'b0, 1'b1);
    end

    enable = 1'b0;
    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/max_unpool_bwd.md
# max_unpool_bwd

Backward-pass counterpart of the max-pooling stage: routes each pooled gradient back to the position in its STRIDE×STRIDE window that held the forward maximum, and writes zero to every other position. Sits between the upstream layer's gradient output and the conv-layer backward block in the training datapath. Processes one window position (all channels in parallel) per clock, so it trades latency for area relative to a fully parallel implementation.

## Interface
- INPUT_WIDTH, 64, forward feature-map width (first index)
- INPUT_HEIGHT, 64, forward feature-map height (second index)
- INPUT_CHANNELS, 30, channel count (third index)
- STRIDE, 2, window size and step; OUT_W = INPUT_WIDTH/STRIDE, OUT_H = INPUT_HEIGHT/STRIDE (integer division)

- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low
- enable  input  1  start request, sampled in IDLE only
- feature_map  input  signed 16 [0:INPUT_WIDTH-1][0:INPUT_HEIGHT-1][0:INPUT_CHANNELS-1]  forward-pass input to the pooling stage; must be held stable from the start edge until unpool_done
- grad_in  input  signed 16 [0:OUT_W-1][0:OUT_H-1][0:INPUT_CHANNELS-1]  upstream gradient; same stability rule
- grad_out  output reg signed 16 [0:INPUT_WIDTH-1][0:INPUT_HEIGHT-1][0:INPUT_CHANNELS-1]  routed gradient
- busy  output  1  high while in RUN or DONE
- unpool_done  output  1  completion flag

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE; grad_out all 0, busy 0, unpool_done 0, window counters i=j=0.
- IDLE: on enable=1 → RUN; i=j=0; unpool_done←0; grad_out fully cleared to 0 (default build). enable=0 holds IDLE, outputs unchanged.
- RUN: each edge processes window (i,j) for every channel k:
  - Argmax over x,y in 0..STRIDE-1 (x outer, y inner) of feature_map[i*STRIDE+x][j*STRIDE+y][k], strict greater-than compare starting from (0,0); ties resolve to the first position in scan order (same winner as forward pooling).
  - Default build: grad_out at argmax ← grad_in[i][j][k]; remaining STRIDE²-1 window positions ← 0.
  - Counter order: j increments first; at j=OUT_H-1, j←0 and i increments. At (OUT_W-1, OUT_H-1) → DONE.
- DONE: one cycle; unpool_done←1; → IDLE. unpool_done stays 1 until the next accepted enable.
- enable is ignored in RUN and DONE; no restart or abort other than reset.
- Rows/columns beyond OUT_W*STRIDE / OUT_H*STRIDE (non-divisible sizes) are never window members; default build leaves them at the 0 written in the start cycle.
- Reset asserted mid-RUN: immediate return to IDLE, all outputs zero, partial results discarded.

## Timing
- Start edge S (IDLE, enable=1): busy=1 after S.
- Window n (0-based, n = i*OUT_H + j) written on edge S+1+n.
- DONE entered after edge S+OUT_W*OUT_H; unpool_done=1 and busy=0 after edge S+OUT_W*OUT_H+1.
- Default params: 1024 RUN cycles; unpool_done rises 1026 edges after start.
- Earliest next start: enable sampled on the edge after unpool_done rises.

## Configuration
- MAX_UNPOOL_ACCUM_EN defined: grad_out is NOT cleared on start; in RUN only the argmax position is updated, grad_out ← grad_out + grad_in computed at 17 bits and saturated to [-32768, 32767]; non-argmax positions untouched. Supports fan-in gradient accumulation across multiple passes.
- Undefined (default): overwrite behaviour as in Operation; no adder present.

## Test plan
- Params W=H=4, C=1, S=2; feature_map window (0,0) = {1,5,3,2} at (0,0),(0,1),(1,0),(1,1), grad_in[0][0]=7 → grad_out[0][1]=7, other three positions 0; unpool_done rises 6 edges after start.
- Tie: window values all 4, grad_in=-3 → grad_out at window (0,0) position = -3, others 0.
- Negative data: window {-8,-2,-9,-2}, grad_in=10 → grad_out at (0,1) = 10 (first of tied maxima), others 0.
- Reset_n low for one cycle mid-RUN (after 2 windows) → grad_out all 0, busy 0, unpool_done 0; subsequent enable runs full 4-window pass correctly.
- enable held high throughout → second pass starts only after unpool_done; enable pulses during RUN do not alter the window sequence.
- MAX_UNPOOL_ACCUM_EN: two passes with grad_in=30000 at same argmax → grad_out=32767 (saturated); non-argmax positions retain pre-loaded nonzero values.
